// File: rtl/keyword_stabilizer.sv
// keyword_stabilizer: debounces a raw keyword ID stream, publishes the stable
// level and issues each newly confirmed non-idle keyword as a valid/ready event.
// Optional post-acceptance holdoff: define KWSTAB_HOLDOFF_EN.
module keyword_stabilizer #(
    parameter int unsigned KW_WIDTH       = 4,
    parameter int unsigned IDLE_KW        = 0,
    parameter int unsigned STABLE_CYCLES  = 50000,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned HOLDOFF_CYCLES = 100000,
    parameter int unsigned HOLD_WIDTH     = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KW_WIDTH-1:0] keyword_input,
    output logic [KW_WIDTH-1:0] keyword_output,
    output logic                kw_valid,
    output logic [KW_WIDTH-1:0] kw_id,
    input  logic                kw_ready,
    output logic                evt_dropped
);

    localparam logic [KW_WIDTH-1:0]  IDLE_V   = KW_WIDTH'(IDLE_KW);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_PRE  = CNT_WIDTH'(STABLE_CYCLES - 2);

    // Parameter sanity checks at elaboration
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("STABLE_CYCLES must be at least 2");
    end
    if ((64'd1 << CNT_WIDTH) <= 64'(STABLE_CYCLES)) begin : g_bad_cnt_width
        $error("CNT_WIDTH too small for STABLE_CYCLES");
    end
    if (HOLDOFF_CYCLES < 1) begin : g_bad_holdoff
        $error("HOLDOFF_CYCLES must be at least 1");
    end
    if ((64'd1 << HOLD_WIDTH) <= 64'(HOLDOFF_CYCLES)) begin : g_bad_hold_width
        $error("HOLD_WIDTH too small for HOLDOFF_CYCLES");
    end

`ifdef KWSTAB_HOLDOFF_EN
    localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(HOLDOFF_CYCLES - 1);
    typedef enum logic [1:0] {EVT_IDLE, EVT_PEND, EVT_HOLD} evt_state_t;
    logic [HOLD_WIDTH-1:0] hold_q;
`else
    typedef enum logic {EVT_IDLE, EVT_PEND} evt_state_t;
`endif

    evt_state_t           state_q;
    logic [KW_WIDTH-1:0]  cand_q, cand_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [KW_WIDTH-1:0]  kw_out_q;
    logic [KW_WIDTH-1:0]  kw_id_q;
    logic                 kw_valid_q;
    logic                 drop_q;
    logic                 confirm;
    logic                 new_level;
    logic                 req;

    // Stability tracker next state: restart on any change, saturate at the confirm point
    always_comb begin
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        confirm = 1'b0;
        if (keyword_input != cand_q) begin
            cand_d = keyword_input;
            cnt_d  = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d   = cnt_q + CNT_WIDTH'(1);
            confirm = (cnt_q == CNT_PRE);
        end
    end

    assign new_level = confirm && (cand_q != kw_out_q);
    assign req       = new_level && (cand_q != IDLE_V);

    // Tracker registers and debounced level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_q   <= IDLE_V;
            cnt_q    <= '0;
            kw_out_q <= IDLE_V;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            if (new_level) begin
                kw_out_q <= cand_q;
            end
        end
    end

    // Event FSM: issue, overwrite (latest wins), accept and optional holdoff
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EVT_IDLE;
            kw_valid_q <= 1'b0;
            kw_id_q    <= IDLE_V;
            drop_q     <= 1'b0;
`ifdef KWSTAB_HOLDOFF_EN
            hold_q     <= '0;
`endif
        end else begin
            drop_q <= 1'b0;
            case (state_q)
                EVT_IDLE: begin
                    if (req) begin
                        kw_id_q    <= cand_q;
                        kw_valid_q <= 1'b1;
                        state_q    <= EVT_PEND;
                    end
                end
                EVT_PEND: begin
                    if (kw_ready) begin
`ifdef KWSTAB_HOLDOFF_EN
                        kw_valid_q <= 1'b0;
                        hold_q     <= '0;
                        state_q    <= EVT_HOLD;
                        if (req) begin
                            drop_q <= 1'b1;
                        end
`else
                        if (req) begin
                            kw_id_q <= cand_q;
                        end else begin
                            kw_valid_q <= 1'b0;
                            state_q    <= EVT_IDLE;
                        end
`endif
                    end else if (req) begin
                        kw_id_q <= cand_q;
                        drop_q  <= 1'b1;
                    end
                end
`ifdef KWSTAB_HOLDOFF_EN
                EVT_HOLD: begin
                    // The last holdoff edge already counts as free: a request there is issued
                    if (hold_q == HOLD_LAST) begin
                        hold_q <= '0;
                        if (req) begin
                            kw_id_q    <= cand_q;
                            kw_valid_q <= 1'b1;
                            state_q    <= EVT_PEND;
                        end else begin
                            state_q <= EVT_IDLE;
                        end
                    end else begin
                        hold_q <= hold_q + HOLD_WIDTH'(1);
                        if (req) begin
                            drop_q <= 1'b1;
                        end
                    end
                end
`endif
                default: state_q <= EVT_IDLE;
            endcase
        end
    end

    assign keyword_output = kw_out_q;
    assign kw_valid       = kw_valid_q;
    assign kw_id          = kw_id_q;
    assign evt_dropped    = drop_q;

endmodule

// File: tb/tb_keyword_stabilizer.sv
// Scoreboard bench for keyword_stabilizer: a run-length / absolute-time model
// pushes the expected post-edge outputs; a monitor pops and compares them.
module tb_keyword_stabilizer;

    localparam int unsigned KW = 4;
    localparam int unsigned S  = 8;
    localparam int unsigned H  = 20;
    localparam logic [KW-1:0] IDLE = 4'd0;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [KW-1:0] keyword_input = '0;
    logic [KW-1:0] keyword_output;
    logic          kw_valid;
    logic [KW-1:0] kw_id;
    logic          kw_ready = 1'b0;
    logic          evt_dropped;

    keyword_stabilizer #(
        .KW_WIDTH(KW), .IDLE_KW(0), .STABLE_CYCLES(S), .CNT_WIDTH(4),
        .HOLDOFF_CYCLES(H), .HOLD_WIDTH(5)
    ) dut (
        .clk(clk), .rst(rst), .keyword_input(keyword_input),
        .keyword_output(keyword_output), .kw_valid(kw_valid), .kw_id(kw_id),
        .kw_ready(kw_ready), .evt_dropped(evt_dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [KW-1:0] out;
        logic          valid;
        logic [KW-1:0] id;
        logic          drop;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   m_acc  = 0;
    int   obs_acc = 0;

    // Reference model state: run length of identical samples, absolute edge time
    logic [KW-1:0] run_val;
    int            run_len;
    logic [KW-1:0] m_out, m_id;
    logic          m_valid, m_drop, m_hold;
    int            e, hold_end;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", n, a, x, $time);
        end
    endfunction

    function automatic void push_exp();
        exp_t x;
        x.out = m_out; x.valid = m_valid; x.id = m_id; x.drop = m_drop;
        exp_q.push_back(x);
    endfunction

    function automatic void model_reset();
        run_val = IDLE; run_len = 1;   // reset candidate counts as the first sample
        m_out = IDLE; m_id = IDLE; m_valid = 0; m_drop = 0; m_hold = 0;
        e = 0; hold_end = 0;
    endfunction

    function automatic void model_edge(logic [KW-1:0] k, logic r);
        bit reached = 0;
        bit req = 0;
        bit acc;
        e++;
        acc = m_valid && r;
        if (k == run_val) begin
            if (run_len < int'(S)) begin
                run_len++;
                reached = (run_len == int'(S));
            end
        end else begin
            run_val = k;
            run_len = 1;
        end
        if (reached && run_val != m_out) begin
            m_out = run_val;
            req = (run_val != IDLE);
        end
        m_drop = 0;
        if (m_hold && e >= hold_end) m_hold = 0;
        if (m_hold) begin
            if (req) m_drop = 1;
        end else if (!m_valid) begin
            if (req) begin m_valid = 1; m_id = run_val; end
        end else if (acc) begin
            m_acc++;
`ifdef KWSTAB_HOLDOFF_EN
            m_valid = 0; m_hold = 1; hold_end = e + int'(H);
            if (req) m_drop = 1;
`else
            if (req) m_id = run_val;
            else m_valid = 0;
`endif
        end else if (req) begin
            m_id = run_val; m_drop = 1;
        end
        push_exp();
    endfunction

    // Monitor: compare DUT outputs against the scoreboard away from the active edge
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (kw_valid === 1'b1 && kw_ready === 1'b1 && rst === 1'b0) obs_acc++;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("keyword_output", 32'(keyword_output), 32'(x.out));
                chk("kw_valid", 32'(kw_valid), 32'(x.valid));
                if (x.valid) chk("kw_id", 32'(kw_id), 32'(x.id));
                chk("evt_dropped", 32'(evt_dropped), 32'(x.drop));
            end
        end
    end

    task automatic step(input logic [KW-1:0] k, input logic r);
        keyword_input = k;
        kw_ready = r;
        @(posedge clk); #1;
        model_edge(k, r);
    endtask

    task automatic hold(input logic [KW-1:0] k, input int n, input logic r);
        for (int i = 0; i < n; i++) step(k, r);
    endtask

    task automatic do_reset(input string tag);
        kw_ready = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk({tag, "_rst_out"},   32'(keyword_output), 32'(IDLE));
        chk({tag, "_rst_valid"}, 32'(kw_valid), 32'd0);
        chk({tag, "_rst_id"},    32'(kw_id), 32'(IDLE));
        chk({tag, "_rst_drop"},  32'(evt_dropped), 32'd0);
        model_reset();
        @(posedge clk); #1;
        push_exp();
        rst = 1'b0;
    endtask

    initial begin
        logic [KW-1:0] pool [5];
        pool[0] = 4'd0; pool[1] = 4'd3; pool[2] = 4'd5; pool[3] = 4'd6; pool[4] = 4'd9;
        model_reset();
        #2;
        do_reset("por");

        // Idle level confirms to itself; then 3 confirmed, accepted
        hold(4'd0, 10, 0);
        hold(4'd3, 10, 0);
        step(4'd3, 1);
        hold(4'd3, 2, 0);

        // Confirm of IDLE updates the level only
        hold(4'd0, 10, 0);

        // Glitch to 5 restarts the count; 5 never confirmed
        hold(4'd3, 7, 0);
        step(4'd5, 0);
        hold(4'd3, 10, 0);
        step(4'd3, 1);

        // Overwrite while pending: latest wins with a drop pulse
        hold(4'd0, 9, 0);
        hold(4'd3, 9, 0);
        hold(4'd6, 9, 0);
        step(4'd6, 1);

        // Holdoff window: 6 confirms at +10, 2 confirms at +25
        hold(4'd0, 9, 0);
        hold(4'd3, 9, 0);
        step(4'd3, 1);
        hold(4'd3, 2, 0);
        hold(4'd6, 15, 0);
        hold(4'd2, 9, 0);
        step(4'd2, 1);
        hold(4'd2, 25, 0);

        // Request and accept on the same edge
        hold(4'd0, 9, 0);
        hold(4'd3, 9, 0);
        hold(4'd6, 7, 0);
        step(4'd6, 1);
        hold(4'd6, 3, 0);
        step(4'd6, 1);
        hold(4'd6, 25, 0);

        // Reset mid-count, then reset with an event pending
        hold(4'd9, 4, 0);
        do_reset("midcnt");
        hold(4'd9, 9, 0);
        chk("pending_before_rst", 32'(kw_valid), 32'd1);
        do_reset("midevt");
        hold(4'd0, 3, 0);

        // Randomized runs with random consumer backpressure
        for (int i = 0; i < 40; i++) begin
            logic [KW-1:0] k;
            int len;
            k = pool[$urandom_range(0, 4)];
            len = $urandom_range(1, 12);
            for (int j = 0; j < len; j++) step(k, $urandom_range(0, 3) == 0);
        end

        kw_ready = 1'b0;
        @(negedge clk); #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("accept_count", 32'(obs_acc), 32'(m_acc));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keyword_stabilizer.md
# keyword_stabilizer

Parametrised keyword debouncer and event generator between the classifier's raw keyword ID stream and the command/display logic. Confirms a keyword once it has been held for a programmable number of cycles, publishes the stable level, and issues each new non-idle keyword as a single valid/ready event. Optional post-acceptance holdoff suppresses echo triggers.

## Interface
- `KW_WIDTH`, 4: keyword ID width.
- `IDLE_KW`, 0: "no keyword" ID; never issued as an event.
- `STABLE_CYCLES`, 50000: consecutive identical samples required to confirm; ≥2.
- `CNT_WIDTH`, 16: stability counter width; 2^CNT_WIDTH > STABLE_CYCLES.
- `HOLDOFF_CYCLES`, 100000: post-acceptance suppression length; ≥1; used only with holdoff compiled in.
- `HOLD_WIDTH`, 17: holdoff counter width; 2^HOLD_WIDTH > HOLDOFF_CYCLES.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `keyword_input` in KW_WIDTH: raw keyword ID, sampled every edge.
- `keyword_output` out KW_WIDTH: debounced keyword level.
- `kw_valid` out 1: event pending.
- `kw_id` out KW_WIDTH: event keyword; stable while `kw_valid`=1 unless overwritten.
- `kw_ready` in 1: consumer accepts when `kw_valid`&&`kw_ready` at an edge.
- `evt_dropped` out 1: one-cycle pulse, an event was overwritten or suppressed.

## Operation
- Reset values: `keyword_output`=IDLE_KW, `kw_id`=IDLE_KW, `kw_valid`=0, `evt_dropped`=0; internal candidate=IDLE_KW, count=0, state EVT_IDLE.
- Tracker, each edge: input≠candidate → candidate<=input, count<=0. Input=candidate and count<STABLE_CYCLES-1 → count+1; if that increment reaches STABLE_CYCLES-1, a confirm fires and `keyword_output`<=candidate. Count saturates at STABLE_CYCLES-1; no further confirms while saturated.
- A confirm with value equal to current `keyword_output` updates nothing and generates no event (glitch and return).
- Confirm of new value V≠IDLE_KW produces an event request; confirm of IDLE_KW updates `keyword_output` only.
- Event FSM:
  - EVT_IDLE: request → `kw_id`<=V, `kw_valid`<=1, go EVT_PEND.
  - EVT_PEND: accept, no request → `kw_valid`<=0, go EVT_HOLD (holdoff built) or EVT_IDLE. Request without accept → `kw_id`<=V (latest wins), `evt_dropped` pulses, stay. Request with accept in same edge → old event accepted; new request discarded with `evt_dropped` pulse if holdoff built, otherwise loaded as next event (`kw_valid` stays 1, new `kw_id`), no drop.
  - EVT_HOLD: holdoff counter runs HOLDOFF_CYCLES edges then → EVT_IDLE. Requests here are discarded with `evt_dropped` pulse; `keyword_output` keeps tracking normally.
- `kw_ready` ignored when `kw_valid`=0.
- `rst` mid-count or mid-event: all state returns to reset values immediately; pending event lost without drop pulse.

## Timing
- Input changes to V before edge k and holds: candidate loads at k; `keyword_output`=V and `kw_valid`=1 visible after edge k+STABLE_CYCLES-1.
- Any differing sample restarts the count from that edge.
- Event accepted at edge a: `kw_valid` low after a; holdoff ends, FSM in EVT_IDLE, after edge a+HOLDOFF_CYCLES; a confirm at that edge or later is issued.
- All outputs registered; no combinational input-to-output path.

## Configuration
- `KWSTAB_HOLDOFF_EN` defined: EVT_HOLD state and holdoff counter present as above.
- Undefined: no EVT_HOLD, no holdoff counter; accept returns straight to EVT_IDLE; HOLDOFF_CYCLES/HOLD_WIDTH unused.

## Test plan
- STABLE_CYCLES=8: input 0→3 held → `keyword_output`=3, `kw_valid`=1, `kw_id`=3 after 8th edge; accept → `kw_valid`=0 next edge.
- Input 3 for 7 edges, 5 for 1 edge, 3 again → count restarts; 3 confirmed 8 edges after return, none earlier; no event for 5.
- Confirm 3, hold `kw_ready`=0, then confirm 6 → `kw_id`=6, `evt_dropped` one pulse, single event.
- Holdoff built, HOLDOFF_CYCLES=20: accept 3, confirm 6 at +10 → `keyword_output`=6, no event, drop pulse; confirm 2 at +25 → event 2.
- Confirm IDLE_KW → `keyword_output`=0, no `kw_valid`; same edge request+accept checked for both macro settings.
- Assert `rst` mid-count and with `kw_valid`=1 → all outputs return to reset values at once.
